// File: rtl/ours_axi_rd_arbiter.sv
// Two-to-one AXI read arbiter: round-robin AR grant into a registered slot, in-order R routing via a route FIFO.
// Optional sticky orphan-R error flag enabled by defining OURS_AXI_RD_ARB_ERR_EN.
module ours_axi_rd_arbiter #(
  parameter int AR_WIDTH        = 32,
  parameter int R_WIDTH         = 64,
  parameter int R_LAST_BIT      = 0,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                slave0_ar_valid,
  input  logic [AR_WIDTH-1:0] slave0_ar_info,
  output logic                slave0_ar_ready,
  input  logic                slave1_ar_valid,
  input  logic [AR_WIDTH-1:0] slave1_ar_info,
  output logic                slave1_ar_ready,
  output logic                slave0_r_valid,
  output logic [R_WIDTH-1:0]  slave0_r_info,
  input  logic                slave0_r_ready,
  output logic                slave1_r_valid,
  output logic [R_WIDTH-1:0]  slave1_r_info,
  input  logic                slave1_r_ready,
  output logic                master_ar_valid,
  output logic [AR_WIDTH-1:0] master_ar_info,
  input  logic                master_ar_ready,
  input  logic                master_r_valid,
  input  logic [R_WIDTH-1:0]  master_r_info,
  output logic                master_r_ready
`ifdef OURS_AXI_RD_ARB_ERR_EN
  ,
  output logic                err_orphan_r
`endif
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic              live;
  logic              prio;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              route_mem [MAX_OUTSTANDING];

  logic slot_free;
  logic grant;
  logic grant_sel;
  logic fifo_nonempty;
  logic head;
  logic push;
  logic pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) live <= 1'b0;
    else       live <= 1'b1;
  end

  // Occupancy is sampled at cycle start, so a same-cycle pop never unblocks a grant.
  always_comb begin
    slot_free     = !master_ar_valid || master_ar_ready;
    grant         = live && slot_free && (count < CNT_W'(MAX_OUTSTANDING)) &&
                    (slave0_ar_valid || slave1_ar_valid);
    grant_sel     = (slave0_ar_valid && slave1_ar_valid) ? prio : slave1_ar_valid;
    fifo_nonempty = (count != '0);
    head          = route_mem[rd_ptr];
  end

  assign slave0_ar_ready = grant && !grant_sel;
  assign slave1_ar_ready = grant && grant_sel;
  assign push            = grant;

  assign slave0_r_info  = master_r_info;
  assign slave1_r_info  = master_r_info;
  assign slave0_r_valid = fifo_nonempty && !head && master_r_valid;
  assign slave1_r_valid = fifo_nonempty && head && master_r_valid;
  assign master_r_ready = fifo_nonempty && (head ? slave1_r_ready : slave0_r_ready);
  assign pop            = master_r_valid && master_r_ready && master_r_info[R_LAST_BIT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      master_ar_valid <= 1'b0;
      master_ar_info  <= '0;
      prio            <= 1'b0;
    end else if (grant) begin
      master_ar_valid <= 1'b1;
      master_ar_info  <= grant_sel ? slave1_ar_info : slave0_ar_info;
      prio            <= !grant_sel;
    end else if (master_ar_ready) begin
      master_ar_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) route_mem[wr_ptr] <= grant_sel;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef OURS_AXI_RD_ARB_ERR_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                err_orphan_r <= 1'b0;
    else if (master_r_valid && !fifo_nonempty) err_orphan_r <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ours_axi_rd_arbiter.sv
// Self-checking bench for ours_axi_rd_arbiter: directed vector table, hand sequences and a randomized queue-based model.
module tb_ours_axi_rd_arbiter;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        v0 = 0, v1 = 0;
  logic [31:0] i0 = 0, i1 = 0;
  logic        arr0, arr1;
  logic        rv0, rv1;
  logic [63:0] ri0, ri1;
  logic        rr0 = 0, rr1 = 0;
  logic        mav;
  logic [31:0] mai;
  logic        mar = 0;
  logic        mrv = 0;
  logic [63:0] mri = 0;
  logic        mrr;
`ifdef OURS_AXI_RD_ARB_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ours_axi_rd_arbiter #(
    .AR_WIDTH(32), .R_WIDTH(64), .R_LAST_BIT(0), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .slave0_ar_valid(v0), .slave0_ar_info(i0), .slave0_ar_ready(arr0),
    .slave1_ar_valid(v1), .slave1_ar_info(i1), .slave1_ar_ready(arr1),
    .slave0_r_valid(rv0), .slave0_r_info(ri0), .slave0_r_ready(rr0),
    .slave1_r_valid(rv1), .slave1_r_info(ri1), .slave1_r_ready(rr1),
    .master_ar_valid(mav), .master_ar_info(mai), .master_ar_ready(mar),
    .master_r_valid(mrv), .master_r_info(mri), .master_r_ready(mrr)
`ifdef OURS_AXI_RD_ARB_ERR_EN
    , .err_orphan_r(err)
`endif
  );

  typedef struct {
    logic v0, v1;
    logic [31:0] i0, i1;
    logic mar, rv, rlast, rr0, rr1;
    logic e_arr0, e_arr1, e_mav;
    logic [31:0] e_mai;
    logic e_rv0, e_rv1, e_mrr;
  } vec_t;

  vec_t vecs[17];

  // Reference model state: outstanding routes as a queue of requester indices.
  int          mq[$];
  bit          m_mav;
  logic [31:0] m_mai;
  int          m_prio;
  bit          m_live;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic zero_inputs();
    v0 = 0; v1 = 0; i0 = 0; i1 = 0; mar = 0; mrv = 0; mri = 0; rr0 = 0; rr1 = 0;
  endtask

  // Ends on a negedge with rstn just released; live sets at the following posedge.
  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    v0 = 1; v1 = 1; mar = 1; mrv = 1; mri = 64'h1; rr0 = 1; rr1 = 1;
    #1;
    check("rst_mav", mav, 0);
    check("rst_mai", mai, 0);
    check("rst_arr0", arr0, 0);
    check("rst_arr1", arr1, 0);
    check("rst_rv0", rv0, 0);
    check("rst_rv1", rv1, 0);
    check("rst_mrr", mrr, 0);
`ifdef OURS_AXI_RD_ARB_ERR_EN
    check("rst_err", err, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    zero_inputs();
    rstn = 1;
    mq.delete(); m_mav = 0; m_mai = 0; m_prio = 0; m_live = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    v0 = v.v0; v1 = v.v1; i0 = v.i0; i1 = v.i1; mar = v.mar;
    mrv = v.rv; mri = {$urandom, $urandom}; mri[0] = v.rlast; rr0 = v.rr0; rr1 = v.rr1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string s;
    s = $sformatf("vec%0d", idx);
    check({s, "_arr0"}, arr0, v.e_arr0);
    check({s, "_arr1"}, arr1, v.e_arr1);
    check({s, "_mav"}, mav, v.e_mav);
    if (v.e_mav) check({s, "_mai"}, mai, v.e_mai);
    check({s, "_rv0"}, rv0, v.e_rv0);
    check({s, "_rv1"}, rv1, v.e_rv1);
    check({s, "_mrr"}, mrr, v.e_mrr);
  endtask

  // One randomized cycle: predict from the queue model, compare, then advance the model.
  task automatic random_cycle();
    bit free, can, sel, pop, last, e_arr0, e_arr1, e_rv0, e_rv1, e_mrr;
    v0 = ($urandom_range(0, 3) != 0); v1 = ($urandom_range(0, 2) != 0);
    i0 = $urandom; i1 = $urandom;
    mar = ($urandom_range(0, 3) != 0);
    mrv = $urandom_range(0, 1);
    mri = {$urandom, $urandom};
    rr0 = ($urandom_range(0, 3) != 0); rr1 = ($urandom_range(0, 3) != 0);
    last = mri[0];
    #1;
    free   = !m_mav || mar;
    can    = m_live && free && (mq.size() < MAXO) && (v0 || v1);
    sel    = (v0 && v1) ? m_prio[0] : v1;
    e_arr0 = can && !sel;
    e_arr1 = can && sel;
    e_rv0  = (mq.size() > 0) && (mq[0] == 0) && mrv;
    e_rv1  = (mq.size() > 0) && (mq[0] == 1) && mrv;
    e_mrr  = (mq.size() > 0) && ((mq[0] == 1) ? rr1 : rr0);
    check("rnd_arr0", arr0, e_arr0);
    check("rnd_arr1", arr1, e_arr1);
    check("rnd_mav", mav, m_mav);
    if (m_mav) check("rnd_mai", mai, m_mai);
    check("rnd_rv0", rv0, e_rv0);
    check("rnd_rv1", rv1, e_rv1);
    check("rnd_mrr", mrr, e_mrr);
    check("rnd_ri0", ri0, mri);
    check("rnd_ri1", ri1, mri);
    pop = mrv && e_mrr && last;
    if (pop) void'(mq.pop_front());
    if (can) begin
      mq.push_back(sel);
      m_mav = 1;
      m_mai = sel ? i1 : i0;
      m_prio = sel ? 0 : 1;
    end else if (mar) begin
      m_mav = 0;
    end
    m_live = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1,0,32'h1000,0,    1,0,0,0,0, 0,0,0,0,          0,0,0};
    vecs[1]  = '{1,0,32'h1000,0,    1,0,0,0,0, 1,0,0,0,          0,0,0};
    vecs[2]  = '{0,0,0,0,           1,1,1,1,0, 0,0,1,32'h1000,   1,0,1};
    vecs[3]  = '{0,0,0,0,           1,0,0,0,0, 0,0,0,0,          0,0,0};
    vecs[4]  = '{1,1,32'hA0,32'hB1, 1,0,0,0,0, 0,1,0,0,          0,0,0};
    vecs[5]  = '{1,1,32'hA0,32'hB1, 1,0,0,0,0, 1,0,1,32'hB1,     0,0,0};
    vecs[6]  = '{1,1,32'hA0,32'hB1, 1,0,0,0,0, 0,1,1,32'hA0,     0,0,0};
    vecs[7]  = '{1,1,32'hA0,32'hB1, 1,0,0,0,0, 1,0,1,32'hB1,     0,0,0};
    vecs[8]  = '{1,1,32'hA0,32'hB1, 1,0,0,0,0, 0,0,1,32'hA0,     0,0,0};
    vecs[9]  = '{1,1,32'hA0,32'hB1, 1,1,1,0,1, 0,0,0,0,          0,1,1};
    vecs[10] = '{1,1,32'hA0,32'hB1, 1,0,0,0,0, 0,1,0,0,          0,0,0};
    vecs[11] = '{1,1,32'hA0,32'hB1, 0,1,0,0,0, 0,0,1,32'hB1,     1,0,0};
    vecs[12] = '{1,1,32'hA0,32'hB1, 0,1,0,1,0, 0,0,1,32'hB1,     1,0,1};
    vecs[13] = '{1,1,32'hA0,32'hB1, 0,1,1,1,0, 0,0,1,32'hB1,     1,0,1};
    vecs[14] = '{1,1,32'hA0,32'hB1, 1,0,0,0,0, 1,0,1,32'hB1,     0,0,0};
    vecs[15] = '{0,0,0,0,           1,1,1,1,0, 0,0,1,32'hA0,     0,1,0};
    vecs[16] = '{0,0,0,0,           1,1,1,0,1, 0,0,0,0,          0,1,1};

    do_reset();
    for (int k = 0; k < 17; k++) begin
      applyStimulus(vecs[k]);
      #1;
      checkOutput(vecs[k], k);
      @(posedge clk);
      @(negedge clk);
    end

    // Reset mid-operation drops the pending slot and outstanding route.
    do_reset();
    @(posedge clk);
    @(negedge clk);
    v0 = 1; i0 = 32'h55; mar = 0;
    #1 check("mid_grant", arr0, 1);
    @(posedge clk);
    @(negedge clk);
    v0 = 0;
    #1;
    check("mid_mav", mav, 1);
    check("mid_mai", mai, 32'h55);
    rstn = 0;
    #1;
    check("mid_rst_mav", mav, 0);
    check("mid_rst_mai", mai, 0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1; mrv = 1; mri = 64'h1; rr0 = 1; rr1 = 1;
    #1;
    check("mid_orphan_mrr", mrr, 0);
    check("mid_orphan_rv0", rv0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("mid_orphan_mrr2", mrr, 0);
    check("mid_orphan_rv0b", rv0, 0);
`ifdef OURS_AXI_RD_ARB_ERR_EN
    check("orphan_err_set", err, 1);
    mrv = 0;
    @(posedge clk);
    @(negedge clk);
    #1 check("orphan_err_sticky", err, 1);
`endif

`ifdef OURS_AXI_RD_ARB_ERR_EN
    do_reset();
    @(posedge clk);
    @(negedge clk);
    mrv = 1; mri = 64'h1; rr0 = 1; rr1 = 1;
    #1;
    check("orphan_err_pre", err, 0);
    check("orphan_mrr", mrr, 0);
    @(posedge clk);
    @(negedge clk);
    mrv = 0;
    #1 check("orphan_err_next", err, 1);
    @(posedge clk);
    @(negedge clk);
    #1 check("orphan_err_hold", err, 1);
`endif

    do_reset();
    for (int c = 0; c < 3000; c++) random_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
